// File: rtl/core_mem_arbiter.sv
// Shares one memory port between the fetch and load/store buses, one transaction at a time.
// Data requests win unless fetch has already waited through MAX_DATA_BURST data grants.
module core_mem_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int MAX_DATA_BURST = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  instr_req_i,
    input  logic                  instr_flush_i,
    input  logic [ADDR_WIDTH-1:0] instr_addr_i,
    output logic                  instr_rsp_o,
    output logic [DATA_WIDTH-1:0] instr_data_o,
    input  logic                  data_rd_i,
    input  logic                  data_wr_i,
    input  logic [ADDR_WIDTH-1:0] data_addr_i,
    input  logic [DATA_WIDTH-1:0] data_wdata_i,
    output logic                  data_rsp_o,
    output logic [DATA_WIDTH-1:0] data_rdata_o,
    output logic                  mem_rd_o,
    output logic                  mem_wr_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic                  mem_rsp_i,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    output logic                  busy_o
);

    localparam int CNT_W = (MAX_DATA_BURST < 1) ? 1 : $clog2(MAX_DATA_BURST + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_INSTR = 2'd1,
        ST_DATA  = 2'd2
    } state_t;

    state_t             state_r;
    state_t             next_state_s;
    logic               drop_r;
    logic [CNT_W-1:0]   burst_cnt_r;
    logic               fetch_ok_s;
    logic               data_ok_s;
    logic               burst_full_s;
    logic               grant_instr_s;
    logic               grant_data_s;

    // Arbitration, next-state and combinational response outputs
    always_comb begin
        next_state_s  = state_r;
        grant_instr_s = 1'b0;
        grant_data_s  = 1'b0;
        fetch_ok_s    = instr_req_i & ~instr_flush_i;
        data_ok_s     = data_rd_i | data_wr_i;
        burst_full_s  = (burst_cnt_r == CNT_W'(MAX_DATA_BURST));
        instr_rsp_o   = 1'b0;
        data_rsp_o    = 1'b0;
        instr_data_o  = mem_rdata_i;
        data_rdata_o  = mem_rdata_i;
        busy_o        = (state_r != ST_IDLE);
        case (state_r)
            ST_IDLE: begin
                // Fetch only overtakes a waiting load/store once its starvation budget is spent
                if (data_ok_s && !(fetch_ok_s && burst_full_s)) begin
                    next_state_s = ST_DATA;
                    grant_data_s = 1'b1;
                end else if (fetch_ok_s) begin
                    next_state_s  = ST_INSTR;
                    grant_instr_s = 1'b1;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_INSTR: begin
                instr_rsp_o = mem_rsp_i & ~drop_r & ~instr_flush_i;
                if (mem_rsp_i) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_INSTR;
                end
            end
            ST_DATA: begin
                data_rsp_o = mem_rsp_i;
                if (mem_rsp_i) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_DATA;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Memory command registers: loaded on grant, held until the memory responds
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_rd_o    <= 1'b0;
            mem_wr_o    <= 1'b0;
            mem_addr_o  <= {ADDR_WIDTH{1'b0}};
            mem_wdata_o <= {DATA_WIDTH{1'b0}};
        end else if (grant_data_s) begin
            mem_wr_o    <= data_wr_i;
            mem_rd_o    <= ~data_wr_i;
            mem_addr_o  <= data_addr_i;
            mem_wdata_o <= data_wdata_i;
        end else if (grant_instr_s) begin
            mem_rd_o   <= 1'b1;
            mem_wr_o   <= 1'b0;
            mem_addr_o <= instr_addr_i;
        end else if ((state_r != ST_IDLE) && mem_rsp_i) begin
            mem_rd_o <= 1'b0;
            mem_wr_o <= 1'b0;
        end
    end

    // A flushed fetch still completes on the bus but its response is swallowed
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_r <= 1'b0;
        end else if (grant_instr_s) begin
            drop_r <= 1'b0;
        end else if (state_r == ST_INSTR) begin
            if (mem_rsp_i) begin
                drop_r <= 1'b0;
            end else if (instr_flush_i) begin
                drop_r <= 1'b1;
            end
        end
    end

    // Consecutive data grants while a fetch is waiting (saturating)
    always_ff @(posedge clk) begin
        if (rst) begin
            burst_cnt_r <= {CNT_W{1'b0}};
        end else if (grant_instr_s) begin
            burst_cnt_r <= {CNT_W{1'b0}};
        end else if (grant_data_s) begin
            if (!instr_req_i) begin
                burst_cnt_r <= {CNT_W{1'b0}};
            end else if (!burst_full_s) begin
                burst_cnt_r <= burst_cnt_r + CNT_W'(1'b1);
            end
        end
    end

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Randomized bench for core_mem_arbiter: requesters, a memory responder and a
// transaction-level reference model all run from one cycle loop.
module tb_core_mem_arbiter;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int MAXB = 4;
    localparam int NCYC = 4000;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          instr_req_i = 1'b0, instr_flush_i = 1'b0;
    logic [AW-1:0] instr_addr_i = '0;
    logic          instr_rsp_o;
    logic [DW-1:0] instr_data_o;
    logic          data_rd_i = 1'b0, data_wr_i = 1'b0;
    logic [AW-1:0] data_addr_i = '0;
    logic [DW-1:0] data_wdata_i = '0;
    logic          data_rsp_o;
    logic [DW-1:0] data_rdata_o;
    logic          mem_rd_o, mem_wr_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_wdata_o;
    logic          mem_rsp_i = 1'b0;
    logic [DW-1:0] mem_rdata_i = '0;
    logic          busy_o;

    always #5 clk = ~clk;

    core_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_DATA_BURST(MAXB)) dut (
        .clk(clk), .rst(rst),
        .instr_req_i(instr_req_i), .instr_flush_i(instr_flush_i), .instr_addr_i(instr_addr_i),
        .instr_rsp_o(instr_rsp_o), .instr_data_o(instr_data_o),
        .data_rd_i(data_rd_i), .data_wr_i(data_wr_i), .data_addr_i(data_addr_i),
        .data_wdata_i(data_wdata_i), .data_rsp_o(data_rsp_o), .data_rdata_o(data_rdata_o),
        .mem_rd_o(mem_rd_o), .mem_wr_o(mem_wr_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_rsp_i(mem_rsp_i), .mem_rdata_i(mem_rdata_i),
        .busy_o(busy_o)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    // Reference model: the single outstanding transaction and who owns it
    bit            m_busy = 1'b0, m_own_data = 1'b0, m_rd = 1'b0, m_wr = 1'b0, m_drop = 1'b0;
    logic [AW-1:0] m_addr  = '0;
    logic [DW-1:0] m_wdata = '0;
    int            m_streak = 0;
    int            mem_wait = 0;
    bit            fetch_pend = 1'b0, data_pend = 1'b0, d_rd = 1'b0, d_wr = 1'b0, stray_next = 1'b0;
    bit            exp_irsp, exp_drsp, f_ok, d_ok;
    int            phase, flush_div, start_div, kind;

    initial begin
        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(posedge clk);
            #1;
            phase     = cyc / 1000;
            flush_div = (phase == 3) ? 3 : 16;
            start_div = (phase == 1) ? 1 : 2;

            // Memory responder, plus stray responses while idle and right after a reset
            mem_rdata_i = $urandom;
            if (m_busy) begin
                if (mem_wait == 0) mem_rsp_i = 1'b1;
                else begin
                    mem_rsp_i = 1'b0;
                    mem_wait--;
                end
            end else begin
                mem_rsp_i = stray_next || ($urandom_range(0, 15) == 0);
            end
            rst        = (cyc < 2) || (phase == 2 && $urandom_range(0, 63) == 0);
            stray_next = rst;

            // Fetch requester: holds until its response; flush redirects the address
            if (!fetch_pend && ($urandom_range(0, start_div - 1) == 0)) begin
                fetch_pend   = 1'b1;
                instr_addr_i = $urandom & 32'hFFFF_FFFC;
            end
            instr_flush_i = (phase != 1) && ($urandom_range(0, flush_div - 1) == 0);
            if (instr_flush_i) instr_addr_i = $urandom & 32'hFFFF_FFFC;
            instr_req_i = fetch_pend;

            // Data requester: loads, stores and occasional rd+wr together
            if (!data_pend && ($urandom_range(0, start_div - 1) == 0)) begin
                data_pend    = 1'b1;
                kind         = $urandom_range(0, 7);
                d_rd         = (kind < 4);
                d_wr         = (kind >= 4) || (kind == 0);
                data_addr_i  = $urandom;
                data_wdata_i = $urandom;
            end
            data_rd_i = data_pend & d_rd;
            data_wr_i = data_pend & d_wr;

            @(negedge clk);
            exp_irsp = m_busy && !m_own_data && mem_rsp_i && !m_drop && !instr_flush_i;
            exp_drsp = m_busy && m_own_data && mem_rsp_i;
            check_eq("busy", busy_o, m_busy);
            check_eq("mem_rd", mem_rd_o, m_rd);
            check_eq("mem_wr", mem_wr_o, m_wr);
            check_eq("mem_addr", mem_addr_o, m_addr);
            if (m_wr || cyc == 0) check_eq("mem_wdata", mem_wdata_o, m_wdata);
            check_eq("instr_rsp", instr_rsp_o, exp_irsp);
            check_eq("data_rsp", data_rsp_o, exp_drsp);
            if (exp_irsp) check_eq("instr_data", instr_data_o, mem_rdata_i);
            if (exp_drsp) check_eq("data_rdata", data_rdata_o, mem_rdata_i);

            if (exp_irsp) fetch_pend = 1'b0;
            if (exp_drsp) data_pend = 1'b0;

            // Advance the model to what the next clock edge should produce
            if (rst) begin
                m_busy = 1'b0; m_rd = 1'b0; m_wr = 1'b0; m_drop = 1'b0;
                m_addr = '0; m_wdata = '0; m_streak = 0;
            end else if (m_busy) begin
                if (!m_own_data && instr_flush_i) m_drop = 1'b1;
                if (mem_rsp_i) begin
                    m_busy = 1'b0; m_rd = 1'b0; m_wr = 1'b0; m_drop = 1'b0;
                end
            end else begin
                f_ok = instr_req_i && !instr_flush_i;
                d_ok = data_rd_i || data_wr_i;
                mem_wait = (phase == 1) ? 0 : $urandom_range(0, 3);
                if (d_ok && !(f_ok && m_streak == MAXB)) begin
                    m_busy = 1'b1; m_own_data = 1'b1;
                    m_wr = data_wr_i; m_rd = !data_wr_i;
                    m_addr = data_addr_i; m_wdata = data_wdata_i;
                    m_streak = instr_req_i ? ((m_streak < MAXB) ? m_streak + 1 : MAXB) : 0;
                end else if (f_ok) begin
                    m_busy = 1'b1; m_own_data = 1'b0;
                    m_rd = 1'b1; m_wr = 1'b0; m_drop = 1'b0;
                    m_addr = instr_addr_i;
                    m_streak = 0;
                end
            end
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
